// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d requantisation path: widths, int8 range
// and the configuration loaded by reset.
package conv1d_pkg;

    localparam int BYTE_SIZE  = 8;
    localparam int INT32_SIZE = 32;
    localparam int LANES      = 4;

    localparam logic signed [INT32_SIZE-1:0] INT8_MIN = -128;
    localparam logic signed [INT32_SIZE-1:0] INT8_MAX = 127;

    localparam logic signed [INT32_SIZE-1:0] RST_BIAS    = 0;
    localparam logic signed [INT32_SIZE-1:0] RST_MULT    = 32'h4000_0000;
    localparam logic        [4:0]            RST_SHIFT   = 5'd0;
    localparam logic signed [INT32_SIZE-1:0] RST_OFFSET  = 0;
    localparam logic signed [INT32_SIZE-1:0] RST_ACT_MIN = INT8_MIN;
    localparam logic signed [INT32_SIZE-1:0] RST_ACT_MAX = INT8_MAX;

endpackage

// File: rtl/conv1d_srdhm.sv
// Saturating rounding doubling high multiply: y = round(a * b / 2^(W-1)),
// with the single overflow case (MIN * MIN) saturated to MAX.
module conv1d_srdhm #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    import conv1d_pkg::*;

    localparam logic signed [2*W-1:0] NUDGE_POS = (2*W)'(1) << (W - 2);
    localparam logic signed [2*W-1:0] NUDGE_NEG = (2*W)'(1) - NUDGE_POS;
    localparam logic [W-1:0] VAL_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] VAL_MAX = {1'b0, {(W-1){1'b1}}};

    logic signed [2*W-1:0] a_ext, b_ext, prod, sum;
    logic [W-1:0] quot;
    logic         round_up;

    always_comb begin
        a_ext = {{W{a[W-1]}}, a};
        b_ext = {{W{b[W-1]}}, b};
        prod  = a_ext * b_ext;
        sum   = prod + (prod[2*W-1] ? NUDGE_NEG : NUDGE_POS);
        // Quotient truncates toward zero: a negative sum with a nonzero
        // remainder moves one step up from the floor produced by the slice.
        round_up = sum[2*W-1] && (sum[W-2:0] != '0);
        quot     = sum[2*W-2:W-1] + {{(W-1){1'b0}}, round_up};
        y        = ((a == VAL_MIN) && (b == VAL_MIN)) ? VAL_MAX : quot;
    end

endmodule

// File: rtl/conv1d_requant.sv
// Four-stage requantiser (bias, high multiply, rounding shift, offset/clamp)
// packing int8 results into 32-bit words, lane 0 in the low byte.
module conv1d_requant #(
    parameter int BYTE_SIZE  = conv1d_pkg::BYTE_SIZE,
    parameter int INT32_SIZE = conv1d_pkg::INT32_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INT32_SIZE-1:0] in_acc,
    input  logic                  in_last,
    input  logic                  cfg_load,
    input  logic [INT32_SIZE-1:0] cfg_bias,
    input  logic [INT32_SIZE-1:0] cfg_mult,
    input  logic [4:0]            cfg_shift,
    input  logic [INT32_SIZE-1:0] cfg_offset,
    input  logic [INT32_SIZE-1:0] cfg_act_min,
    input  logic [INT32_SIZE-1:0] cfg_act_max,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INT32_SIZE-1:0] out_word,
    output logic                  out_last,
    output logic                  busy
);
    import conv1d_pkg::*;

    localparam int W  = INT32_SIZE;
    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    logic [W-1:0] bias, mult, offset, act_min, act_max;
    logic [4:0]   shift;

    logic                 s1_valid, s2_valid, s3_valid, s4_valid;
    logic                 s1_last, s2_last, s3_last, s4_last;
    logic [W-1:0]         s1_sum, s2_val, s3_val;
    logic [BYTE_SIZE-1:0] s4_byte;

    logic [W-1:0]         pack_word;
    logic [LW-1:0]        lane_cnt;

    logic stall, hs, cfg_take, write;
    logic [W-1:0] srdhm_y, one_sh, mask, rem, thr, div_y;
    logic signed [W:0] ofs_sum, lo, hi;
    logic [BYTE_SIZE-1:0] clamp_byte;

    // The pack register can only be overwritten once the presented word
    // leaves, so a waiting S4 element freezes the whole pipe.
    assign stall    = out_valid && !out_ready && s4_valid;
    assign in_ready = !stall;
    assign hs       = in_valid && in_ready;
    assign write    = s4_valid && !stall;
    assign busy     = s1_valid || s2_valid || s3_valid || s4_valid ||
                      (lane_cnt != '0) || out_valid;
    assign cfg_take = cfg_load && !busy && !in_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            bias    <= W'(RST_BIAS);
            mult    <= W'(RST_MULT);
            shift   <= RST_SHIFT;
            offset  <= W'(RST_OFFSET);
            act_min <= W'(RST_ACT_MIN);
            act_max <= W'(RST_ACT_MAX);
        end else if (cfg_take) begin
            bias    <= cfg_bias;
            mult    <= cfg_mult;
            shift   <= cfg_shift;
            offset  <= cfg_offset;
            act_min <= cfg_act_min;
            act_max <= cfg_act_max;
        end
    end

    conv1d_srdhm #(.W(W)) u_srdhm (
        .a (s1_sum),
        .b (mult),
        .y (srdhm_y)
    );

    always_comb begin
        one_sh = W'(1) << shift;
        mask   = one_sh - W'(1);
        rem    = s2_val & mask;
        thr    = (mask >> 1) + {{(W-1){1'b0}}, s2_val[W-1]};
        div_y  = W'($signed(s2_val) >>> shift) + {{(W-1){1'b0}}, (rem > thr)};
    end

    always_comb begin
        ofs_sum = $signed({s3_val[W-1], s3_val}) + $signed({offset[W-1], offset});
        lo      = $signed({act_min[W-1], act_min});
        hi      = $signed({act_max[W-1], act_max});
        if (ofs_sum < lo) begin
            clamp_byte = act_min[BYTE_SIZE-1:0];
        end else if (ofs_sum > hi) begin
            clamp_byte = act_max[BYTE_SIZE-1:0];
        end else begin
            clamp_byte = ofs_sum[BYTE_SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
            s3_last  <= 1'b0;
            s4_last  <= 1'b0;
            s1_sum   <= '0;
            s2_val   <= '0;
            s3_val   <= '0;
            s4_byte  <= '0;
        end else if (!stall) begin
            s1_valid <= hs;
            s1_last  <= in_last;
            s1_sum   <= in_acc + bias;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_val   <= srdhm_y;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_val   <= div_y;
            s4_valid <= s3_valid;
            s4_last  <= s3_last;
            s4_byte  <= clamp_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pack_word <= '0;
            lane_cnt  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (write) begin
                // Lane 0 starts a fresh word, clearing lanes a short row never reaches.
                if (lane_cnt == '0) begin
                    pack_word <= {{(W-BYTE_SIZE){1'b0}}, s4_byte};
                end else begin
                    pack_word[lane_cnt*BYTE_SIZE +: BYTE_SIZE] <= s4_byte;
                end
                if ((lane_cnt == LAST_LANE) || s4_last) begin
                    out_valid <= 1'b1;
                    out_last  <= s4_last;
                    lane_cnt  <= '0;
                end else begin
                    lane_cnt  <= lane_cnt + LW'(1);
                end
            end
        end
    end

    assign out_word = pack_word;

endmodule

// File: tb/tb_conv1d_requant.sv
// Directed bench for conv1d_requant: reset state, default and custom
// requantisation, saturation, short rows, back-pressure and mid-run reset.
module tb_conv1d_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        in_last;
    logic        cfg_load;
    logic [31:0] cfg_bias, cfg_mult, cfg_offset, cfg_act_min, cfg_act_max;
    logic [4:0]  cfg_shift;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_last;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    conv1d_requant dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .in_last     (in_last),
        .cfg_load    (cfg_load),
        .cfg_bias    (cfg_bias),
        .cfg_mult    (cfg_mult),
        .cfg_shift   (cfg_shift),
        .cfg_offset  (cfg_offset),
        .cfg_act_min (cfg_act_min),
        .cfg_act_max (cfg_act_max),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_last    (out_last),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input logic [31:0] acc, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("handshake_wait", 32'(n < 100), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 100), 32'd1);
    endtask

    task automatic do_cfg(input logic [31:0] b, input logic [31:0] m, input logic [4:0] s,
                          input logic [31:0] o, input logic [31:0] lo, input logic [31:0] hi);
        wait_idle();
        cfg_bias    = b;
        cfg_mult    = m;
        cfg_shift   = s;
        cfg_offset  = o;
        cfg_act_min = lo;
        cfg_act_max = hi;
        cfg_load    = 1'b1;
        @(negedge clk);
        cfg_load    = 1'b0;
    endtask

    task automatic wait_out(input string tag, input logic [31:0] word, input logic last);
        int n = 0;
        while (!out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_wait"}, 32'(n < 30), 32'd1);
        check({tag, "_word"}, out_word, word);
        check({tag, "_last"}, 32'(out_last), 32'(last));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_acc      = '0;
        in_last     = 1'b0;
        cfg_load    = 1'b0;
        cfg_bias    = '0;
        cfg_mult    = '0;
        cfg_shift   = '0;
        cfg_offset  = '0;
        cfg_act_min = '0;
        cfg_act_max = '0;
        out_ready   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word",  out_word,       32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Defaults: halving multiplier, exact 4-cycle latency
        send(32'd100, 1'b0);
        send(32'd50,  1'b0);
        send(-32'sd30, 1'b0);
        send(32'd0,   1'b0);
        repeat (3) @(negedge clk);
        check("def_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("def_valid", 32'(out_valid), 32'd1);
        check("def_word",  out_word, 32'h00F1_1932);
        check("def_last",  32'(out_last), 32'd0);
        @(negedge clk);
        check("def_drained_busy", 32'(busy), 32'd0);

        // MIN * MIN saturates then clamps to 127 in every lane
        do_cfg(32'd0, 32'h8000_0000, 5'd0, 32'd0, -32'sd128, 32'd127);
        repeat (4) send(32'h8000_0000, 1'b0);
        wait_out("sat", 32'h7F7F_7F7F, 1'b0);

        // Rounding shift by 2, last on 4th element
        do_cfg(32'd0, 32'h4000_0000, 5'd2, 32'd0, -32'sd128, 32'd127);
        send(32'd20,  1'b0);
        send(-32'sd20, 1'b0);
        send(32'd6,   1'b0);
        send(-32'sd6,  1'b1);
        wait_out("shift2", 32'hFF01_FD03, 1'b1);

        // Offset -128 with clamping, short row of two
        do_cfg(32'd0, 32'h4000_0000, 5'd0, -32'sd128, -32'sd128, 32'd127);
        send(32'd1000,   1'b0);
        send(-32'sd1000, 1'b1);
        wait_out("offset", 32'h0000_807F, 1'b1);

        // Back-pressure: 8 elements with out_ready low
        do_cfg(32'd0, 32'h4000_0000, 5'd0, 32'd0, -32'sd128, 32'd127);
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(32'(2 * i), 1'b0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_valid",        32'(out_valid), 32'd1);
        check("bp_word1",        out_word, 32'h0403_0201);
        repeat (3) @(negedge clk);
        check("bp_word1_hold",   out_word, 32'h0403_0201);
        check("bp_last_hold",    32'(out_last), 32'd0);
        check("bp_still_stall",  32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_word1_taken",  32'(out_valid), 32'd0);
        wait_out("bp_word2", 32'h0807_0605, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_no_dup_valid", 32'(out_valid), 32'd0);
        check("bp_idle",         32'(busy), 32'd0);

        // cfg_load while busy is ignored
        send(32'd2, 1'b0);
        send(32'd2, 1'b0);
        check("busy_before_cfg", 32'(busy), 32'd1);
        cfg_bias = 32'd100;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        send(32'd4, 1'b0);
        send(32'd4, 1'b0);
        wait_out("cfg_ignored", 32'h0202_0101, 1'b0);

        // Reset mid-stream discards partial word
        send(32'd10, 1'b0);
        send(32'd12, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy",      32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_word",  out_word, 32'd0);
        send(32'd6,  1'b0);
        send(32'd8,  1'b0);
        send(32'd10, 1'b0);
        send(32'd12, 1'b0);
        wait_out("post_rst", 32'h0605_0403, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
